// File: rtl/page_board_render.sv
// page_board_render: pipelined VGA renderer for the game board.
// Draws ROWS x COLS 2x-scaled digit tiles using an external synchronous font ROM.
// Ports:
//   vga_clk, vga_rst   pixel clock, async active-high reset
//   x_pos, y_pos       current pixel coordinate
//   total_number       active tiles per row (0 or >COLS means COLS)
//   status             packed tile digits, tile t at [4t+3:4t]
//   cur_player         player to move
//   cur_select         cursor tile index
//   selected           locked tile index
//   selecting          selected is valid
//   game_end           0 playing, 1 p0 won, 2 p1 won, 3 draw
//   rom_addr, rom_data font ROM address out, pixel bit back ROM_LAT cycles later
//   pixel_data         {B,G,R} colour, 2+ROM_LAT cycles after x_pos/y_pos
module page_board_render #(
    parameter int ROWS         = 2,
    parameter int COLS         = 5,
    parameter int TILE_W       = 80,
    parameter int TILE_H       = 128,
    parameter int ROW_Y0       = 86,
    parameter int ROW_PITCH    = 180,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 30,
    parameter int FLASH_FRAMES = 20,
    parameter int IDXW         = $clog2(ROWS * COLS)
) (
    input  logic                   vga_clk,
    input  logic                   vga_rst,
    input  logic [9:0]             x_pos,
    input  logic [9:0]             y_pos,
    input  logic [3:0]             total_number,
    input  logic [ROWS*COLS*4-1:0] status,
    input  logic                   cur_player,
    input  logic [IDXW-1:0]        cur_select,
    input  logic [IDXW-1:0]        selected,
    input  logic                   selecting,
    input  logic [1:0]             game_end,
    output logic [14:0]            rom_addr,
    input  logic                   rom_data,
    output logic [11:0]            pixel_data
);

    localparam int NT  = ROWS * COLS;
    localparam int FW  = $clog2(FLASH_FRAMES + 1);
    localparam int BW  = $clog2(BLINK_FRAMES);
    // Glyph is 32 source columns doubled, centred in the tile
    localparam int GX0 = (TILE_W - 64) / 2;

    typedef struct packed {
        logic        border;
        logic        glyph_en;
        logic [11:0] glyph_col;
        logic [11:0] bg;
    } flags_t;

    logic [NT*4-1:0] r_shadow;
    logic [FW-1:0]   r_flash [NT];
    logic [BW-1:0]   r_blink_cnt;
    logic            r_blink_phase;
    logic            r_primed;
    logic [14:0]     r_rom_addr;
    flags_t          r_dly [ROM_LAT+1];
    logic [11:0]     r_pix;

    logic [3:0]      w_n;
    logic [9:0]      w_left;
    logic            w_hit;
    logic            w_row_odd;
    logic            w_flash;
    logic [IDXW-1:0] w_tile;
    logic [6:0]      w_dx;
    logic [6:0]      w_dy;
    logic [3:0]      w_digit;
    logic            w_gbox;
    logic            w_edge;
    logic            w_fs;
    logic [4:0]      w_gx;
    logic [5:0]      w_gy;
    logic [14:0]     w_addr;
    flags_t          w_flags;

    assign w_n = (total_number == 4'd0 || int'(total_number) > COLS)
                 ? 4'(COLS) : total_number;
    assign w_left = 10'(320 - (TILE_W * int'(w_n)) / 2);

    // Tile hit test; digit and flash state come from the frame-frozen copy
    always_comb begin
        w_hit     = 1'b0;
        w_row_odd = 1'b0;
        w_tile    = '0;
        w_dx      = '0;
        w_dy      = '0;
        w_digit   = '0;
        w_flash   = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (c < int'(w_n) &&
                    x_pos >= w_left + 10'(c * TILE_W) &&
                    x_pos <  w_left + 10'((c + 1) * TILE_W) &&
                    y_pos >= 10'(ROW_Y0 + r * ROW_PITCH) &&
                    y_pos <  10'(ROW_Y0 + r * ROW_PITCH + TILE_H)) begin
                    w_hit     = 1'b1;
                    w_row_odd = 1'(r);
                    w_tile    = IDXW'(r * COLS + c);
                    w_dx      = 7'(x_pos - w_left - 10'(c * TILE_W));
                    w_dy      = 7'(y_pos - 10'(ROW_Y0 + r * ROW_PITCH));
                    w_digit   = r_shadow[4*(r*COLS+c) +: 4];
                    w_flash   = r_flash[r*COLS+c] != '0;
                end
            end
        end
    end

    assign w_gbox = w_hit && w_dx >= 7'(GX0) && w_dx < 7'(GX0 + 64);
    assign w_gx   = 5'((w_dx - 7'(GX0)) >> 1);
    assign w_gy   = w_dy[6:1];
    assign w_addr = 15'(w_digit) * 15'd32 + 15'(w_gx) + 15'(w_gy) * 15'd320;
    assign w_edge = w_dx < 7'd4 || w_dx >= 7'(TILE_W - 4) ||
                    w_dy < 7'd4 || w_dy >= 7'(TILE_H - 4);
    assign w_fs   = x_pos == 10'd0 && y_pos == 10'd0;

    // Colour decisions made up front; only the ROM bit is applied late
    always_comb begin
        w_flags = '0;
        w_flags.border = w_hit && w_edge && w_tile == cur_select &&
                         game_end == 2'd0 && (!r_blink_phase || selecting);
        w_flags.glyph_en = w_gbox && w_digit <= 4'd9;
        if (w_flash)
            w_flags.glyph_col = 12'hf00;
        else if (selecting && w_tile == selected && game_end == 2'd0)
            w_flags.glyph_col = 12'h0f0;
        else
            w_flags.glyph_col = 12'h000;
        if (!w_hit)
            w_flags.bg = 12'hfff;
        else if ((game_end == 2'd1 && !w_row_odd) ||
                 (game_end == 2'd2 && w_row_odd))
            w_flags.bg = 12'h8f8;
        else if (game_end == 2'd3)
            w_flags.bg = 12'hccc;
        else if (w_row_odd == cur_player)
            w_flags.bg = 12'hfff;
        else
            w_flags.bg = 12'haaa;
    end

    // Frame-start bookkeeping: board snapshot, flash timers, cursor blink
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            r_shadow      <= '0;
            r_primed      <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            for (int t = 0; t < NT; t++)
                r_flash[t] <= '0;
        end else if (w_fs) begin
            r_shadow <= status;
            r_primed <= 1'b1;
            if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
            for (int t = 0; t < NT; t++) begin
                if (r_primed && status[4*t +: 4] != r_shadow[4*t +: 4])
                    r_flash[t] <= FW'(FLASH_FRAMES);
                else if (r_flash[t] != '0)
                    r_flash[t] <= r_flash[t] - FW'(1);
            end
        end
    end

    // Pixel pipeline: classify, wait out the ROM, compose
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            r_rom_addr <= '0;
            r_pix      <= '0;
            for (int i = 0; i <= ROM_LAT; i++)
                r_dly[i] <= '0;
        end else begin
            r_rom_addr <= w_gbox ? w_addr : '0;
            r_dly[0]   <= w_flags;
            for (int i = 1; i <= ROM_LAT; i++)
                r_dly[i] <= r_dly[i-1];
            if (r_dly[ROM_LAT].border)
                r_pix <= 12'h00f;
            else if (r_dly[ROM_LAT].glyph_en && rom_data)
                r_pix <= r_dly[ROM_LAT].glyph_col;
            else
                r_pix <= r_dly[ROM_LAT].bg;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign pixel_data = r_pix;

endmodule

// File: tb/tb_page_board_render.sv
// tb_page_board_render: scoreboard bench for page_board_render.
// Font ROM model returns address bit 0, so odd glyph columns are lit.
module tb_page_board_render;

    logic        vga_clk      = 1'b0;
    logic        vga_rst      = 1'b1;
    logic [9:0]  x_pos        = 10'd639;
    logic [9:0]  y_pos        = 10'd479;
    logic [3:0]  total_number = 4'd5;
    logic [39:0] status       = '0;
    logic        cur_player   = 1'b0;
    logic [3:0]  cur_select   = 4'd15;
    logic [3:0]  selected     = 4'd0;
    logic        selecting    = 1'b0;
    logic [1:0]  game_end     = 2'd0;
    logic [14:0] rom_addr;
    logic        rom_data     = 1'b0;
    logic [11:0] pixel_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nframes  = 0;

    int          pq_due[$];
    logic [11:0] pq_val[$];
    string       pq_nm[$];
    int          aq_due[$];
    logic [14:0] aq_val[$];
    string       aq_nm[$];

    int          m_due;
    logic [11:0] m_pv;
    logic [14:0] m_av;
    string       m_nm;

    int dig [10] = '{3, 1, 5, 7, 8, 0, 9, 4, 6, 2};

    page_board_render dut (
        .vga_clk      (vga_clk),
        .vga_rst      (vga_rst),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .total_number (total_number),
        .status       (status),
        .cur_player   (cur_player),
        .cur_select   (cur_select),
        .selected     (selected),
        .selecting    (selecting),
        .game_end     (game_end),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pixel_data   (pixel_data)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_addr[0];
    end

    // Monitor: pop expectations whose due cycle has arrived
    always @(negedge vga_clk) begin
        while (pq_due.size() > 0 && pq_due[0] <= cyc) begin
            m_due = pq_due.pop_front();
            m_pv  = pq_val.pop_front();
            m_nm  = pq_nm.pop_front();
            checks++;
            if (m_due != cyc || pixel_data !== m_pv) begin
                failures++;
                $display("FAIL %s: pixel_data=%h cycle %0d, expected %h cycle %0d",
                         m_nm, pixel_data, cyc, m_pv, m_due);
            end
        end
        while (aq_due.size() > 0 && aq_due[0] <= cyc) begin
            m_due = aq_due.pop_front();
            m_av  = aq_val.pop_front();
            m_nm  = aq_nm.pop_front();
            checks++;
            if (m_due != cyc || rom_addr !== m_av) begin
                failures++;
                $display("FAIL %s: rom_addr=%0d cycle %0d, expected %0d cycle %0d",
                         m_nm, rom_addr, cyc, m_av, m_due);
            end
        end
    end

    task automatic px(input int x, input int y);
        @(posedge vga_clk);
        #1;
        x_pos = 10'(x);
        y_pos = 10'(y);
    endtask

    task automatic gap();
        px(639, 479);
    endtask

    task automatic fs();
        px(0, 0);
        px(639, 479);
        nframes++;
    endtask

    task automatic chk(input int x, input int y, input logic [11:0] ep,
                       input string nm);
        px(x, y);
        pq_due.push_back(cyc + 3);
        pq_val.push_back(ep);
        pq_nm.push_back(nm);
    endtask

    task automatic chka(input int x, input int y, input logic [14:0] ea,
                        input logic [11:0] ep, input string nm);
        chk(x, y, ep, nm);
        aq_due.push_back(cyc + 1);
        aq_val.push_back(ea);
        aq_nm.push_back(nm);
    endtask

    task automatic dchk(input string nm, input logic [31:0] got,
                        input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    initial begin
        for (int t = 0; t < 10; t++)
            status[4*t +: 4] = 4'(dig[t]);

        repeat (3) @(posedge vga_clk);
        #1;
        dchk("rst_pixel", 32'(pixel_data), 32'h0);
        dchk("rst_rom_addr", 32'(rom_addr), 32'h0);

        // Mid-line reset
        vga_rst = 1'b0;
        px(130, 96);
        px(132, 96);
        px(134, 96);
        px(136, 96);
        #2;
        vga_rst = 1'b1;
        #1;
        dchk("midrst_pixel", 32'(pixel_data), 32'h0);
        dchk("midrst_rom_addr", 32'(rom_addr), 32'h0);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        vga_rst = 1'b0;
        nframes = 0;

        // Before any frame start the snapshot holds digit 0
        chka(130, 96, 15'd1601, 12'h000, "pre_fs_glyph");
        fs();

        // T1: digit 3 in tile 0, N=5
        chka(130, 96, 15'd1697, 12'h000, "t1_glyph");
        chka(132, 96, 15'd1698, 12'hfff, "t1_glyph_off");
        chka(191, 213, 15'd20287, 12'h000, "t1_glyph_corner");
        chk(192, 96, 12'hfff, "t1_box_right");
        chk(130, 85, 12'hfff, "above_row0");
        chka(130, 266, 15'd1, 12'h000, "row1_glyph");
        chk(132, 266, 12'haaa, "row1_bg_p0");

        // T2: geometry and background per player
        gap();
        cur_player = 1'b1;
        chk(132, 96, 12'haaa, "row0_bg_p1");
        chk(132, 266, 12'hfff, "row1_bg_p1");
        chk(119, 100, 12'hfff, "n5_left_out");
        chk(120, 100, 12'haaa, "n5_left_in");
        chk(519, 100, 12'haaa, "n5_right_in");
        chk(520, 100, 12'hfff, "n5_right_out");
        chk(130, 214, 12'hfff, "below_row0");
        gap();
        total_number = 4'd3;
        chk(199, 100, 12'hfff, "n3_left_out");
        chk(200, 100, 12'haaa, "n3_left_in");
        chk(439, 100, 12'haaa, "n3_right_in");
        chk(440, 100, 12'hfff, "n3_right_out");
        chka(210, 96, 15'd1697, 12'h000, "n3_glyph");
        gap();
        total_number = 4'd0;
        chk(120, 100, 12'haaa, "n0_clamp_in");
        chk(119, 100, 12'hfff, "n0_clamp_out");
        gap();
        total_number = 4'd9;
        chk(519, 100, 12'haaa, "n9_clamp");
        gap();
        total_number = 4'd5;
        cur_player = 1'b0;

        // T3: blinking cursor on tile 7
        gap();
        cur_select = 4'd7;
        chk(300, 300, 12'haaa, "cursor_interior");
        chk(300, 393, 12'h00f, "cursor_bottom");
        while (nframes <= 60) begin
            if (nframes == 45) begin
                gap();
                selecting = 1'b1;
                chk(280, 300, 12'h00f, "blink_sel_steady");
                gap();
                selecting = 1'b0;
            end
            chk(280, 300, ((nframes / 30) % 2 == 0) ? 12'h00f : 12'haaa,
                "blink_border");
            fs();
        end
        gap();
        cur_select = 4'd15;

        // T4: tile 2 changes 5 -> 2 mid-frame
        chka(290, 96, 15'd1761, 12'h000, "t4_before");
        status[11:8] = 4'd2;
        chka(290, 96, 15'd1761, 12'h000, "t4_hold");
        fs();
        for (int j = 0; j <= 20; j++) begin
            if (j == 0) begin
                chka(290, 96, 15'd1665, 12'hf00, "t4_new_addr");
                chk(370, 96, 12'h000, "t4_neighbour");
            end
            chk(290, 96, (j < 20) ? 12'hf00 : 12'h000, "t4_flash");
            fs();
        end

        // T5: selection and game end
        gap();
        selecting = 1'b1;
        selected  = 4'd4;
        chk(450, 96, 12'h0f0, "sel_glyph");
        chk(370, 96, 12'h000, "unsel_glyph");
        gap();
        game_end = 2'd2;
        chk(450, 96, 12'h000, "ge2_glyph");
        gap();
        cur_select = 4'd4;
        chk(440, 96, 12'hfff, "ge2_no_border");
        chk(132, 266, 12'h8f8, "ge2_row1_win");
        chk(132, 96, 12'hfff, "ge2_row0_p0");
        gap();
        cur_player = 1'b1;
        chk(132, 96, 12'haaa, "ge2_row0_p1");
        gap();
        game_end = 2'd1;
        chk(132, 96, 12'h8f8, "ge1_row0_win");
        chk(132, 266, 12'hfff, "ge1_row1_p1");
        gap();
        game_end = 2'd3;
        chk(132, 96, 12'hccc, "ge3_draw");
        chk(450, 96, 12'h000, "ge3_glyph");
        gap();
        game_end   = 2'd0;
        cur_player = 1'b0;
        cur_select = 4'd15;

        // T6: invalid digit and out-of-range cursor
        status[3:0] = 4'd12;
        fs();
        chka(130, 96, 15'd1985, 12'hfff, "d12_bg");
        chk(120, 96, 12'hfff, "sel15_no_border");
        gap();
        cur_select = 4'd0;
        chk(120, 96, 12'h00f, "border_left");
        chk(130, 89, 12'h00f, "border_top");
        chk(130, 90, 12'hfff, "border_dy4");

        for (int i = 0; i < 50 && (pq_due.size() > 0 || aq_due.size() > 0); i++)
            @(posedge vga_clk);
        if (pq_due.size() > 0 || aq_due.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d pixel and %0d addr expectations pending, expected 0",
                     pq_due.size(), aq_due.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
